// File: rtl/ws2812_pkg.sv
// ws2812_pkg
//   Shared timing constants and state encoding for the WS2812B pixel
//   transmitter. All timings are in cycles of the 20 MHz system clock.
package ws2812_pkg;

   localparam int PIXEL_W      = 24;
   localparam int T0H          = 8;     // 0.40 us high for a '0'
   localparam int T1H          = 16;    // 0.80 us high for a '1'
   localparam int T_BIT        = 25;    // 1.25 us full bit period
   localparam int RESET_CYCLES = 1200;  // 60 us latch gap

   localparam int CNT_MAX = (T_BIT > RESET_CYCLES) ? T_BIT : RESET_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(PIXEL_W);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

endpackage

// File: rtl/ws2812_pixel_tx.sv
// ws2812_pixel_tx
//   Serialises one 24-bit GRB word (bit 23 first) onto a WS2812B data line.
//   A latched word is followed by a RESET_CYCLES low gap so the strip
//   displays the frame.
// Ports
//   clk      in   system clock (20 MHz)
//   rst_n    in   synchronous active-low reset
//   data_in  in   pixel word, sampled only on acceptance
//   valid    in   word offered; taken when valid & ready at a clock edge
//   latch    in   with valid: last pixel of the frame, append reset gap
//   ready    out  registered; high while idle and able to accept
//   led      out  registered serial line to the strip
module ws2812_pixel_tx
   import ws2812_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PIXEL_W-1:0] data_in,
   input  logic               valid,
   input  logic               latch,
   output logic               ready,
   output logic               led
);

   state_t             r_state,   w_state;
   logic [PIXEL_W-1:0] r_shift,   w_shift;
   logic               r_lat,     w_lat;
   logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt;
   logic [CNT_W-1:0]   r_cyc_cnt, w_cyc_cnt;
   logic               r_ready,   w_ready;
   logic               r_led,     w_led;

   // High/low split of the current bit; the shift register only moves at the
   // end of LOW, so both phases of a bit see the same MSB.
   logic [CNT_W-1:0]   w_th;
   logic [CNT_W-1:0]   w_tl;

   assign w_th = r_shift[PIXEL_W-1] ? CNT_W'(T1H) : CNT_W'(T0H);
   assign w_tl = CNT_W'(T_BIT) - w_th;

   assign ready = r_ready;
   assign led   = r_led;

   always_comb begin
      w_state   = r_state;
      w_shift   = r_shift;
      w_lat     = r_lat;
      w_bit_cnt = r_bit_cnt;
      w_cyc_cnt = r_cyc_cnt + CNT_ONE;
      w_ready   = r_ready;
      w_led     = r_led;

      case (r_state)
         ST_IDLE: begin
            w_led     = 1'b0;
            w_ready   = 1'b1;
            w_cyc_cnt = '0;
            // Acceptance uses the registered ready, so the first edge after
            // reset only raises ready and never takes a word.
            if (valid && r_ready) begin
               w_shift   = data_in;
               w_lat     = latch;
               w_bit_cnt = BIT_W'(PIXEL_W - 1);
               w_ready   = 1'b0;
               w_led     = 1'b1;
               w_state   = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (r_cyc_cnt == w_th - CNT_ONE) begin
               w_led     = 1'b0;
               w_cyc_cnt = '0;
               w_state   = ST_LOW;
            end
         end
         ST_LOW: begin
            if (r_cyc_cnt == w_tl - CNT_ONE) begin
               w_cyc_cnt = '0;
               if (r_bit_cnt != '0) begin
                  w_shift   = {r_shift[PIXEL_W-2:0], 1'b0};
                  w_bit_cnt = r_bit_cnt - BIT_W'(1);
                  w_led     = 1'b1;
                  w_state   = ST_HIGH;
               end else if (r_lat) begin
                  w_state   = ST_GAP;
               end else begin
                  w_ready   = 1'b1;
                  w_state   = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (r_cyc_cnt == CNT_W'(RESET_CYCLES - 1)) begin
               w_cyc_cnt = '0;
               w_ready   = 1'b1;
               w_state   = ST_IDLE;
            end
         end
         default: begin
            w_led   = 1'b0;
            w_ready = 1'b0;
            w_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_lat     <= 1'b0;
         r_bit_cnt <= '0;
         r_cyc_cnt <= '0;
         r_ready   <= 1'b0;
         r_led     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_shift   <= w_shift;
         r_lat     <= w_lat;
         r_bit_cnt <= w_bit_cnt;
         r_cyc_cnt <= w_cyc_cnt;
         r_ready   <= w_ready;
         r_led     <= w_led;
      end
   end

endmodule
